// File: rtl/bcd_converter_if.sv
// Start/result bundle for the binary-to-BCD converter.
// o_Blank is present only when BCD_BLANK_EN is defined.
interface bcd_converter_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  i_Start;
    logic [WIDTH-1:0]      i_Value;
    logic                  o_Busy;
    logic                  o_Done;
    logic [4*DIGITS-1:0]   o_Bcd;
`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0]     o_Blank;

    modport master (
        output i_Start, i_Value,
        input  o_Busy, o_Done, o_Bcd, o_Blank
    );

    modport slave (
        input  i_Start, i_Value,
        output o_Busy, o_Done, o_Bcd, o_Blank
    );
`else
    modport master (
        output i_Start, i_Value,
        input  o_Busy, o_Done, o_Bcd
    );

    modport slave (
        input  i_Start, i_Value,
        output o_Busy, o_Done, o_Bcd
    );
`endif
endinterface

// File: rtl/bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional leading-zero flags on o_Blank when BCD_BLANK_EN is defined.
module bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic           i_Clock,
    input  logic           i_Reset_n,
    bcd_converter_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state, next_state;
    logic [WIDTH-1:0] shreg, next_shreg;
    logic [BW-1:0]   scratch, next_scratch;
    logic [CW-1:0]   cnt, next_cnt;
    logic            busy, next_busy;
    logic            done, next_done;
    logic [BW-1:0]   bcd, next_bcd;
    logic [BW-1:0]   adj;
    logic [BW-1:0]   shifted;

    // Add-3 correction on every digit >= 5, then shift in the next binary bit
    always_comb begin
        adj = scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (adj[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
        end
        shifted = {adj[BW-2:0], shreg[WIDTH-1]};
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
        end else begin
            state   <= next_state;
            shreg   <= next_shreg;
            scratch <= next_scratch;
            cnt     <= next_cnt;
            busy    <= next_busy;
            done    <= next_done;
            bcd     <= next_bcd;
        end
    end

    always_comb begin
        next_state   = state;
        next_shreg   = shreg;
        next_scratch = scratch;
        next_cnt     = cnt;
        next_busy    = busy;
        next_done    = 1'b0;
        next_bcd     = bcd;
        unique case (state)
            IDLE: begin
                if (bus.i_Start) begin
                    next_shreg   = bus.i_Value;
                    next_scratch = '0;
                    next_cnt     = CW'(WIDTH);
                    next_busy    = 1'b1;
                    next_state   = SHIFT;
                end
            end
            SHIFT: begin
                next_scratch = shifted;
                next_shreg   = {shreg[WIDTH-2:0], 1'b0};
                next_cnt     = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    next_bcd   = shifted;
                    next_done  = 1'b1;
                    next_busy  = 1'b0;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.o_Busy = busy;
    assign bus.o_Done = done;
    assign bus.o_Bcd  = bcd;

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank, next_blank;
    logic [DIGITS-1:0] blank_calc;
    logic              zero_run;

    // A digit blanks only when it and every digit above it are zero
    always_comb begin
        blank_calc = '0;
        zero_run   = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run      = zero_run && (shifted[4*k +: 4] == 4'd0);
            blank_calc[k] = zero_run;
        end
    end

    always_comb begin
        next_blank = blank;
        if (state == SHIFT && cnt == CW'(1))
            next_blank = blank_calc;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n)
            blank <= '0;
        else
            blank <= next_blank;
    end

    assign bus.o_Blank = blank;
`endif
endmodule
